// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} in HI/LO order after 33 cycles.
module iter_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    logic             abort;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign abort  = flush | annul_i;
    assign accept = (state == IDLE) && start_i && !abort;
    assign last   = (cnt == CW'(WIDTH - 1));

    // One restoring step; the remainder always fits WIDTH bits afterwards.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign ge      = (rem_sh >= {1'b0, dvs});
    assign trial   = rem_sh[WIDTH-1:0] - dvs;
    assign rem_nxt = ge ? trial : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ge};

    assign a_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (opdata2_i == '0) ? ZERO : BUSY;
                end
            end
            ZERO:    next_state = abort ? IDLE : DONE;
            BUSY: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_raw  <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_raw <= opdata1_i;
                        dvs     <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        cnt     <= '0;
                        neg_q   <= signed_div_i &
                                   (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r   <= signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
                ZERO: begin
                    if (!abort) begin
                        result_o <= {dvd_raw, {WIDTH{1'b1}}};
                    end
                end
                BUSY: begin
                    if (!abort) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            result_o <= {neg_r ? -rem_nxt : rem_nxt,
                                         neg_q ? -quo_nxt : quo_nxt};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: latency, signs, divide-by-zero,
// flush/annul/reset aborts and back-to-back requests.
module tb_iter_div_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic        ready_o;
    logic [63:0] result_o;

    int total = 0;
    int bad   = 0;

    iter_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input int lat,
                           input logic [63:0] exp_res, input string nm,
                           input bit toggle);
        int n;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sg;
        start_i      = 1'b1;
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (toggle) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            if (ready_o) break;
        end
        start_i = 1'b0;
        total++;
        if (n !== lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
        end
        total++;
        if (result_o !== exp_res) begin
            bad++;
            $display("FAIL %s result: got %h want %h", nm, result_o, exp_res);
        end
        tick();
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_drop: got %b want 0", nm, ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; annul_i = 1'b0; start_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0; signed_div_i = 1'b0;
        tick();
        tick();
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++;
            $display("FAIL reset: got %b/%h want 0/0", ready_o, result_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        run_div(32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E,
                "u100_7", 1'b0);
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 33, 64'h00000000_FFFFFFFF,
                "uffff_1", 1'b0);
    endtask

    task automatic test_signed();
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 33, 64'hFFFFFFFF_FFFFFFFD,
                "sm7_2", 1'b0);
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 33, 64'h00000001_FFFFFFFD,
                "s7_m2", 1'b0);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 64'h00000000_80000000,
                "s_ovf", 1'b0);
    endtask

    task automatic test_div_zero();
        run_div(32'd5, 32'd0, 1'b0, 2, 64'h00000005_FFFFFFFF,
                "u5_0", 1'b0);
        run_div(32'h80000000, 32'd0, 1'b1, 2, 64'h80000000_FFFFFFFF,
                "s_min_0", 1'b0);
    endtask

    task automatic test_flush();
        logic [63:0] prev;
        bit seen;
        prev = result_o;
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        start_i = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL flush_ready: got 1 want 0");
        end
        total++;
        if (result_o !== prev) begin
            bad++;
            $display("FAIL flush_hold: got %h want %h", result_o, prev);
        end
        run_div(32'd9, 32'd3, 1'b0, 33, 64'h00000000_00000003,
                "after_flush", 1'b0);
    endtask

    task automatic test_async_reset();
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        start_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++;
            $display("FAIL async_rst: got %b/%h want 0/0", ready_o, result_o);
        end
        tick();
        rst = 1'b0;
        tick();
        run_div(32'd45, 32'd6, 1'b0, 33, 64'h00000003_00000007,
                "after_rst", 1'b0);
    endtask

    task automatic test_annul();
        logic [63:0] prev;
        bit seen;
        prev = result_o;
        opdata1_i = 32'd50; opdata2_i = 32'd0; signed_div_i = 1'b0;
        start_i = 1'b1;
        annul_i = 1'b1;
        tick();
        start_i = 1'b0;
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        total++;
        if (seen || result_o !== prev) begin
            bad++;
            $display("FAIL annul: got ready=%b res=%h want 0/%h",
                     seen, result_o, prev);
        end
    endtask

    task automatic test_toggle();
        run_div(32'd1000, 32'd10, 1'b0, 33, 64'h00000000_00000064,
                "toggle", 1'b1);
    endtask

    task automatic test_back_to_back();
        int n;
        opdata1_i = 32'd20; opdata2_i = 32'd6; signed_div_i = 1'b0;
        start_i = 1'b1;
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (ready_o) break;
        end
        total++;
        if (n !== 33 || result_o !== 64'h00000002_00000003) begin
            bad++;
            $display("FAIL b2b_first: got %0d/%h want 33/%h",
                     n, result_o, 64'h00000002_00000003);
        end
        opdata1_i = 32'd50; opdata2_i = 32'd5;
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (ready_o) break;
        end
        start_i = 1'b0;
        total++;
        if (n !== 34 || result_o !== 64'h00000000_0000000A) begin
            bad++;
            $display("FAIL b2b_second: got %0d/%h want 34/%h",
                     n, result_o, 64'h00000000_0000000A);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_flush();
        test_async_reset();
        test_annul();
        test_toggle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
